ifu_ibuf: RTL and testbench

IFU_IBUF -- requirements
Module: ifu_ibuf

---
 rtl/ifu_ibuf_pkg.sv | 20 ++
 rtl/ifu_ibuf.sv | 70 +++++++
 tb/tb_ifu_ibuf.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ifu_ibuf_pkg.sv
// Shared IFU/IDU definitions: fetch-to-decode entry widths, base opcodes
// and the instruction-buffer entry layout.
package ifu_ibuf_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ibuf_entry_t;

endpackage

// File: rtl/ifu_ibuf.sv
// Fetch-to-decode instruction buffer: circular FIFO of {pc, inst} with
// registered full/almost-full, decode stall hold and global flush.
module ifu_ibuf
    import ifu_ibuf_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                      clk,
    input  logic                      rst_clk,
    input  logic                      rtu_global_flush,
    input  logic                      y_idu_id_stall_ctrl,
    input  logic                      ifu_ibuf_inst_vld,
    input  logic [PC_W-1:0]           ifu_ibuf_inst_pc,
    input  logic [INST_W-1:0]         ifu_ibuf_inst,
    output logic                      ibuf_ifu_full,
    output logic                      ibuf_ifu_afull,
    output logic                      ifu_idu_id_inst_vld,
    output logic [PC_W-1:0]           ifu_idu_id_inst_pc,
    output logic [INST_W-1:0]         ifu_idu_id_inst,
    output logic [$clog2(DEPTH):0]    ibuf_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ibuf_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               wr_en, rd_en;
    ibuf_entry_t        head;

    // Full/afull come from registered cnt only, so a same-cycle dequeue
    // never opens a slot for the write.
    assign ibuf_ifu_full  = (cnt == CNT_W'(DEPTH));
    assign ibuf_ifu_afull = (int'(DEPTH) - int'(cnt)) <= AFULL_MARGIN;

    assign ifu_idu_id_inst_vld = (cnt != '0);
    assign wr_en = ifu_ibuf_inst_vld & ~ibuf_ifu_full & ~rtu_global_flush;
    assign rd_en = ifu_idu_id_inst_vld & ~y_idu_id_stall_ctrl & ~rtu_global_flush;

    // Storage is unreset; the empty mask below hides stale contents.
    assign head               = mem[rd_ptr];
    assign ifu_idu_id_inst_pc = ifu_idu_id_inst_vld ? head.pc   : '0;
    assign ifu_idu_id_inst    = ifu_idu_id_inst_vld ? head.inst : '0;
    assign ibuf_cnt           = cnt;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{pc: ifu_ibuf_inst_pc, inst: ifu_ibuf_inst};
        end
    end

    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (rtu_global_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

endmodule

// File: tb/tb_ifu_ibuf.sv
// Bench for ifu_ibuf: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_ifu_ibuf;
    import ifu_ibuf_pkg::*;

    localparam int DEPTH = 8;
    localparam int AFULL_MARGIN = 2;

    logic              clk = 1'b0;
    logic              rst_clk = 1'b1;
    logic              flush = 1'b0;
    logic              stall = 1'b0;
    logic              wvld = 1'b0;
    logic [PC_W-1:0]   wpc = '0;
    logic [INST_W-1:0] winst = '0;
    logic              full, afull, vld;
    logic [PC_W-1:0]   opc;
    logic [INST_W-1:0] oinst;
    logic [3:0]        cnt;

    ifu_ibuf #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) dut (
        .clk                 (clk),
        .rst_clk             (rst_clk),
        .rtu_global_flush    (flush),
        .y_idu_id_stall_ctrl (stall),
        .ifu_ibuf_inst_vld   (wvld),
        .ifu_ibuf_inst_pc    (wpc),
        .ifu_ibuf_inst       (winst),
        .ibuf_ifu_full       (full),
        .ibuf_ifu_afull      (afull),
        .ifu_idu_id_inst_vld (vld),
        .ifu_idu_id_inst_pc  (opc),
        .ifu_idu_id_inst     (oinst),
        .ibuf_cnt            (cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    ibuf_entry_t    mq[$];
    logic [63:0]    dq_log[$];

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] + 32'h13;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of entries.
    always @(posedge rst_clk) mq.delete();
    always @(posedge clk) begin
        if (rst_clk || flush) begin
            mq.delete();
        end else begin
            automatic bit do_wr = wvld && (mq.size() < DEPTH);
            if (mq.size() != 0 && !stall) void'(mq.pop_front());
            if (do_wr) mq.push_back('{pc: wpc, inst: winst});
        end
    end

    // Record what decode actually consumed, for ordering checks.
    always @(posedge clk) begin
        if (!rst_clk && vld && !stall && !flush) dq_log.push_back(opc);
    end

    always @(negedge clk) begin
        automatic int n = mq.size();
        chk("m_vld",   {63'b0, vld},   {63'b0, n != 0});
        chk("m_pc",    opc,            n != 0 ? mq[0].pc : 64'h0);
        chk("m_inst",  {32'b0, oinst}, n != 0 ? {32'b0, mq[0].inst} : 64'h0);
        chk("m_full",  {63'b0, full},  {63'b0, n == DEPTH});
        chk("m_afull", {63'b0, afull}, {63'b0, (DEPTH - n) <= AFULL_MARGIN});
        chk("m_cnt",   {60'b0, cnt},   64'(n));
    end

    task automatic step(input logic v, input logic [63:0] pc, input logic st, input logic fl);
        wvld = v; wpc = pc; winst = inst_of(pc); stall = st; flush = fl;
        @(posedge clk); #2;
    endtask

    task automatic idle();
        wvld = 1'b0; wpc = '0; winst = '0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 32 && vld; c++) step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("drain_empty", {63'b0, vld}, 64'h0);
    endtask

    initial begin
        logic [63:0] next_pc;
        bit          acc;

        repeat (2) @(posedge clk);
        #2 rst_clk = 1'b0;
        chk("rst_vld",   {63'b0, vld},   64'h0);
        chk("rst_pc",    opc,            64'h0);
        chk("rst_full",  {63'b0, full},  64'h0);
        chk("rst_afull", {63'b0, afull}, 64'h0);
        chk("rst_cnt",   {60'b0, cnt},   64'h0);

        // Fill under stall
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 64'h1000 + 64'(4 * i), 1'b1, 1'b0);
            if (i == 4) chk("fill5_afull", {63'b0, afull}, 64'h0);
            if (i == 5) chk("fill6_afull", {63'b0, afull}, 64'h1);
            if (i == 6) chk("fill7_full",  {63'b0, full},  64'h0);
        end
        chk("fill_full", {63'b0, full}, 64'h1);
        chk("fill_cnt",  {60'b0, cnt},  64'h8);
        step(1'b1, 64'h1020, 1'b1, 1'b0);
        chk("drop_cnt",  {60'b0, cnt},  64'h8);
        chk("drop_head", opc,           64'h1000);

        // Drain with continuous writes and retry-on-full across wrap
        dq_log.delete();
        next_pc = 64'h1020;
        for (int c = 0; c < 64 && dq_log.size() < 16; c++) begin
            acc = (next_pc <= 64'h103C) && (mq.size() < DEPTH);
            step(next_pc <= 64'h103C, next_pc, 1'b0, 1'b0);
            if (acc) next_pc += 4;
        end
        chk("wrap_len", 64'(dq_log.size()), 64'd16);
        for (int i = 0; i < 16 && i < dq_log.size(); i++)
            chk("wrap_order", dq_log[i], 64'h1000 + 64'(4 * i));
        idle();
        drain();

        // Empty latency, no bypass
        wvld = 1'b1; wpc = 64'h2000; winst = 32'h00000013; stall = 1'b1;
        #1;
        chk("lat_vld_n",  {63'b0, vld},   64'h0);
        chk("lat_pc_n",   opc,            64'h0);
        chk("lat_inst_n", {32'b0, oinst}, 64'h0);
        @(posedge clk); #2;
        chk("lat_vld_n1",  {63'b0, vld},   64'h1);
        chk("lat_pc_n1",   opc,            64'h2000);
        chk("lat_inst_n1", {32'b0, oinst}, 64'h13);
        idle();
        drain();

        // Flush with write and dequeue active
        for (int i = 0; i < 5; i++) step(1'b1, 64'h3000 + 64'(4 * i), 1'b1, 1'b0);
        step(1'b1, 64'h3014, 1'b0, 1'b0);
        chk("fl_pre_cnt", {60'b0, cnt}, 64'h5);
        step(1'b1, 64'h3018, 1'b1, 1'b1);
        chk("fl_cnt", {60'b0, cnt}, 64'h0);
        chk("fl_vld", {63'b0, vld}, 64'h0);
        step(1'b1, 64'h4000, 1'b1, 1'b0);
        chk("fl_after_cnt", {60'b0, cnt}, 64'h1);
        chk("fl_after_pc",  opc,          64'h4000);
        idle();
        drain();

        // Stall stability
        for (int i = 0; i < 3; i++) step(1'b1, 64'h5000 + 64'(4 * i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 64'h500C + 64'(4 * i), 1'b1, 1'b0);
            chk("stall_head", opc, 64'h5000);
        end
        chk("stall_cnt", {60'b0, cnt}, 64'h7);
        dq_log.delete();
        idle();
        drain();
        chk("stall_len", 64'(dq_log.size()), 64'd7);
        for (int i = 0; i < 7 && i < dq_log.size(); i++)
            chk("stall_order", dq_log[i], 64'h5000 + 64'(4 * i));

        // Asynchronous reset between edges
        for (int i = 0; i < 4; i++) step(1'b1, 64'h6000 + 64'(4 * i), 1'b1, 1'b0);
        idle();
        chk("ar_pre_cnt", {60'b0, cnt}, 64'h4);
        #1 rst_clk = 1'b1;
        #1;
        chk("ar_vld",  {63'b0, vld},  64'h0);
        chk("ar_full", {63'b0, full}, 64'h0);
        chk("ar_cnt",  {60'b0, cnt},  64'h0);
        chk("ar_pc",   opc,           64'h0);
        @(posedge clk); #2 rst_clk = 1'b0;
        step(1'b1, 64'hA000, 1'b1, 1'b0);
        chk("ar_first_vld", {63'b0, vld}, 64'h1);
        chk("ar_first_pc",  opc,          64'hA000);
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
